game_sequencer: RTL
===================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter GOODIE_N, default 9: number of goodies tracked.
REQ-002 SHALL have parameter WIN_COUNT, default 9: goodies needed to win, range 1..GOODIE_N.
REQ-003 SHALL have parameter END_HOLD_FRAMES, default 180: frames the WIN/LOSE screen is held.
REQ-004 SHALL have parameter TIMEOUT_FRAMES, default 3600: PLAY frame limit, used only with PLAY_TIMEOUT_EN.
REQ-005 SHALL have port clk, input, 1: system clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port frame_tick, input, 1: one-cycle pulse per video frame.
REQ-008 SHALL have port start_btn, input, 1: debounced start button level.
REQ-009 SHALL have port collision, input, 1: player/pipe overlap level from the collision detector.
REQ-010 SHALL have port goodie_hit, input, GOODIE_N: per-goodie player overlap level.
REQ-011 SHALL have ports idle, play, win, lose, output, 1 each: registered one-hot screen select for the draw controller.
REQ-012 SHALL have port goodie_taken, output, GOODIE_N: sticky collected flags; bit i drives sig_goodie_(i+1).
REQ-013 SHALL have port score, output, 4: count of set goodie_taken bits.
REQ-014 SHALL have port pos_reset, output, 1: one-cycle pulse that re-homes the player and the pipes.

Function
REQ-015 SHALL implement states IDLE, PLAY, WIN, LOSE; exactly one of idle/play/win/lose SHALL be high in every cycle.
REQ-016 SHALL detect a start press as a rising edge: start_btn high while the registered copy start_q is low.
REQ-017 IDLE -> PLAY on a start press; pos_reset SHALL pulse high for exactly the first PLAY cycle; goodie_taken, score and the frame counters SHALL clear on entry.
REQ-018 In PLAY, each cycle, every bit with goodie_hit[i]=1 and goodie_taken[i]=0 SHALL set goodie_taken[i]; score SHALL increase by the number of bits newly set in that cycle, including several at once; no saturation is needed because score is at most GOODIE_N.
REQ-019 A goodie already taken SHALL never re-count, whatever goodie_hit does.
REQ-020 PLAY -> LOSE when collision=1; collision SHALL take priority over every other transition in the same cycle.
REQ-021 PLAY -> WIN when registered score >= WIN_COUNT and collision=0; the goodie that reaches WIN_COUNT SHALL produce win one cycle after score updates.
REQ-022 In WIN and LOSE, goodie_taken and score SHALL hold; goodie_hit and collision SHALL be ignored.
REQ-023 In WIN/LOSE, a hold counter SHALL count frame_tick pulses; on the END_HOLD_FRAMES-th pulse the block SHALL enter IDLE.
REQ-024 A start press in WIN/LOSE SHALL return the block to IDLE on the next cycle; it SHALL NOT start PLAY directly.
REQ-025 In IDLE, goodie_hit, collision and frame_tick SHALL be ignored.
REQ-026 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, idle=1, play=win=lose=0, goodie_taken=0, score=0, pos_reset=0, all counters 0.
REQ-028 start_q SHALL reset to 1, so a button held through reset does not start a game until it is released and pressed again.
REQ-029 rst asserted mid-PLAY SHALL abort to IDLE in the same edge with no pos_reset pulse.

Configuration
REQ-030 With macro PLAY_TIMEOUT_EN defined, a PLAY frame counter SHALL count frame_tick pulses; on the TIMEOUT_FRAMES-th pulse without a win, PLAY -> LOSE, with collision and win taking precedence in that cycle.
REQ-031 Without PLAY_TIMEOUT_EN, no PLAY frame counter SHALL exist and PLAY SHALL end only by collision or win.

Verification
REQ-032 Reset with start_btn held high, then keep it high for 10 cycles -> idle stays 1; release then press -> play=1 and pos_reset pulses exactly 1 cycle.
REQ-033 In PLAY, pulse goodie_hit=9'h005 for 3 cycles, then 9'h007 -> score=2 then 3, goodie_taken=9'h007.
REQ-034 WIN_COUNT=9, score=8, then the final goodie_hit and collision in the same cycle -> lose=1, win never asserted.
REQ-035 Reach WIN, give 180 frame_tick pulses -> idle=1 exactly after the 180th; repeat with a start press after 5 ticks -> idle next cycle.
REQ-036 With PLAY_TIMEOUT_EN and TIMEOUT_FRAMES=4, no hits or collision -> lose=1 after the 4th frame_tick; without the macro -> play stays 1 after 100 ticks.
REQ-037 Assert rst mid-PLAY with score=5 -> next cycle idle=1, score=0, goodie_taken=0.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: top-level game flow controller (IDLE -> PLAY -> WIN/LOSE -> IDLE).
// Tracks collected goodies and the score, and selects which screen the draw controller shows.
// Optional feature: define PLAY_TIMEOUT_EN to end PLAY as a loss after TIMEOUT_FRAMES frames.
module game_sequencer #(
  parameter int GOODIE_N        = 9,
  parameter int WIN_COUNT       = 9,
  parameter int END_HOLD_FRAMES = 180,
  parameter int TIMEOUT_FRAMES  = 3600
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                start_btn,
  input  logic                collision,
  input  logic [GOODIE_N-1:0] goodie_hit,
  output logic                idle,
  output logic                play,
  output logic                win,
  output logic                lose,
  output logic [GOODIE_N-1:0] goodie_taken,
  output logic [3:0]          score,
  output logic                pos_reset
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_WIN,
    ST_LOSE
  } state_t;

  localparam int HOLD_W = $clog2(END_HOLD_FRAMES + 1);

  state_t              state;
  state_t              next_state;
  logic                start_q;
  logic                start_press;
  logic [GOODIE_N-1:0] new_bits;
  logic [3:0]          add_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_cnt_next;
  logic                enter_play;

`ifdef PLAY_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_FRAMES + 1);
  logic [TO_W-1:0] play_cnt;
  logic [TO_W-1:0] play_cnt_next;
  logic            timeout_hit;
`endif

  assign start_press = start_btn & ~start_q;
  assign new_bits    = goodie_hit & ~goodie_taken;
  assign enter_play  = (state == ST_IDLE) && (next_state == ST_PLAY);

  // Count how many goodies are being collected for the first time this cycle.
  always_comb begin
    add_cnt = '0;
    for (int i = 0; i < GOODIE_N; i++) begin
      add_cnt = add_cnt + {3'b000, new_bits[i]};
    end
  end

`ifdef PLAY_TIMEOUT_EN
  // PLAY frame counter; it rests at zero outside PLAY so every game starts from a fresh budget.
  always_comb begin
    play_cnt_next = '0;
    timeout_hit   = 1'b0;
    if (state == ST_PLAY) begin
      play_cnt_next = play_cnt;
      if (frame_tick) begin
        if (play_cnt == TO_W'(TIMEOUT_FRAMES - 1)) begin
          timeout_hit = 1'b1;
        end else begin
          play_cnt_next = play_cnt + 1'b1;
        end
      end
    end
  end

  // Register the PLAY frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      play_cnt <= '0;
    end else begin
      play_cnt <= play_cnt_next;
    end
  end
`endif

  // Next-state logic; collision beats a win, and a win beats the optional timeout.
  always_comb begin
    next_state    = state;
    hold_cnt_next = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (start_press) begin
          next_state = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (collision) begin
          next_state = ST_LOSE;
        end else if (score >= 4'(WIN_COUNT)) begin
          next_state = ST_WIN;
        end
`ifdef PLAY_TIMEOUT_EN
        else if (timeout_hit) begin
          next_state = ST_LOSE;
        end
`endif
      end
      ST_WIN, ST_LOSE: begin
        if (start_press) begin
          next_state = ST_IDLE;
        end else if (frame_tick) begin
          if (hold_cnt == HOLD_W'(END_HOLD_FRAMES - 1)) begin
            next_state = ST_IDLE;
          end else begin
            hold_cnt_next = hold_cnt + 1'b1;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
    if (next_state != ST_WIN && next_state != ST_LOSE) begin
      hold_cnt_next = '0;
    end
  end

  // State, hold counter and start-button history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      start_q  <= 1'b1;
    end else begin
      state    <= next_state;
      hold_cnt <= hold_cnt_next;
      start_q  <= start_btn;
    end
  end

  // Goodie flags and score: cleared when a game starts, accumulate only while playing.
  always_ff @(posedge clk) begin
    if (rst) begin
      goodie_taken <= '0;
      score        <= '0;
    end else if (enter_play) begin
      goodie_taken <= '0;
      score        <= '0;
    end else if (state == ST_PLAY) begin
      goodie_taken <= goodie_taken | new_bits;
      score        <= score + add_cnt;
    end
  end

  // Registered one-hot screen select and the re-home pulse for the first PLAY cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle      <= 1'b1;
      play      <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
      pos_reset <= 1'b0;
    end else begin
      idle      <= (next_state == ST_IDLE);
      play      <= (next_state == ST_PLAY);
      win       <= (next_state == ST_WIN);
      lose      <= (next_state == ST_LOSE);
      pos_reset <= enter_play;
    end
  end

endmodule
